pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter owner for the multicycle MIPS core; consumes jump_addr_selection from branch_control.
//  Steps FETCH/EXEC. Computes the J/JAL, JR/JALR and branch targets during the jump instruction's EXEC.
//  Applies the selected target at the end of the delay-slot EXEC. Drives the instruction address, state and link address.
//  Detects the halt condition (jump to HALT_ADDR) and then deasserts active.
// PARAMETERS
//  RESET_VECTOR  32'hBFC0_0000  pc value after reset
//  HALT_ADDR     32'h0000_0000  pc target that terminates execution
// PORTS
//  clk                  in   1   rising-edge clock
//  reset                in   1   synchronous, active-high
//  stall                in   1   hold EXEC (multi-cycle LW); honoured only when state=1
//  jump_addr_selection  in   2   00 none, 01 absolute (rs), 10 page-absolute, 11 pc-relative
//  instr_word           in   32  current instruction, valid during EXEC
//  rs_data              in   32  register rs read data, valid during EXEC
//  pc                   out  32  instruction address
//  state                out  1   0=FETCH, 1=EXEC
//  link_addr            out  32  pc+8, the link value for JAL/JALR/BxxZAL
//  active               out  1   high until halt
//  addr_misaligned      out  1   present only with PC_ALIGN_CHECK_EN
// BEHAVIOUR
//  Reset values:
//  - pc=RESET_VECTOR, state=0, active=1; all target registers 0; addr_misaligned=0.
//  - Reset asserted mid-instruction discards pending targets; the first post-reset cycle is FETCH.
//  FSM (two states):
//  - FETCH->EXEC unconditionally while active=1.
//  - EXEC->FETCH when stall=0; EXEC holds with stall=1.
//  - active=0: state forced to 0; pc and targets frozen.
//  Commit edge = posedge with state=1 and stall=0. Every commit:
//  - tgt_abs  <= rs_data
//  - tgt_page <= {pc4[31:28], instr_word[25:0], 2'b00}, where pc4 = pc+4
//  - tgt_rel  <= pc4 + {{14{instr_word[15]}}, instr_word[15:0], 2'b00}
//  - next pc selected by the jump_addr_selection value present at this commit:
//    00 -> pc+4, 01 -> tgt_abs, 10 -> tgt_page, 11 -> tgt_rel.
//  - The target registers are read before being overwritten: registered values from the previous instruction are used.
//  - Net effect: the jump redirects after exactly one delay-slot instruction.
//  Latency and arithmetic:
//  - A jump's target is visible on pc 2 commits after the jump's own EXEC (jump, then delay slot, then target fetch).
//  - All adds are 32-bit modulo; pc 32'hFFFF_FFFC + 4 wraps to 0.
//  - A wrap to 0 via sequential increment also halts when HALT_ADDR=0.
//  - link_addr = pc+8 (combinational, modulo 2^32); it is valid while the jump occupies EXEC.
//  Halt: if next pc == HALT_ADDR at a commit:
//  - pc <= HALT_ADDR and active <= 0 on the same edge.
//  - Thereafter no further commits occur until reset.
//  Branch in a delay slot:
//  - The outer jump's selection is applied.
//  - The inner jump's targets are captured normally and applied at the following commit.
//  - No further special handling.
//  Stall:
//  - Registers hold; a jump_addr_selection change during a stall is ignored until the commit edge.
//  - stall with state=0 has no effect.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//  - At a commit whose selected next pc has bits[1:0]!=0, addr_misaligned <= 1 (sticky until reset).
//  - pc <= HALT_ADDR and active <= 0; the misaligned address is never fetched.
//  - Only the 01 path (JR/JALR) can produce a misaligned target.
//  PC_ALIGN_CHECK_EN undefined:
//  - Port and logic absent; bits[1:0] are passed through unchanged.
// TESTING
//  1. Reset: reset high 2 cycles -> pc=BFC00000, state=0, active=1.
//     Release -> state toggles 0,1,0,1; pc increments by 4 on each EXEC commit.
//  2. BEQ at BFC00000, imm=16'h0004, sel=11 on the delay-slot commit -> pc sequence:
//     BFC00000, BFC00004, BFC00014.
//  3. JR at BFC00008 with rs=0, sel=01 on the delay-slot commit -> pc goes to 0 after BFC0000C.
//     active drops on that edge; state then stays 0 and pc stays frozen.
//  4. Stall: EXEC held 3 cycles with stall=1 -> pc, state and targets unchanged.
//     The commit after stall drops advances pc by exactly 4.
//  5. J at BFC00010, index 26'h0000100 -> pc=B0000400 after the delay slot.
//     link_addr=BFC00018 during the J's EXEC.
//  6. With PC_ALIGN_CHECK_EN: JR with rs=BFC00022 -> addr_misaligned=1, active=0, pc=0.
//     Without the macro the same stimulus gives pc=BFC00022.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter owner for the multicycle MIPS core: FETCH/EXEC stepping, delayed-jump targets, halt.
// Optional macro PC_ALIGN_CHECK_EN adds the sticky addr_misaligned output and halts on misaligned targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  jump_addr_selection,
  input  logic [31:0] instr_word,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic        state,
  output logic [31:0] link_addr,
  output logic        active
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        addr_misaligned
`endif
);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t      cur_state, next_state;
  logic [31:0] tgt_abs, tgt_page, tgt_rel;
  logic [31:0] pc4, sel_pc;
  logic        commit, halt_now;
  logic        unused_bits;

  assign state       = cur_state;
  assign pc4         = pc + 32'd4;
  assign link_addr   = pc + 32'd8;
  assign commit      = active && (cur_state == EXEC) && !stall;
  assign unused_bits = ^instr_word[31:26];

  always_comb begin
    next_state = cur_state;
    if (!active) begin
      next_state = FETCH;
    end else begin
      case (cur_state)
        FETCH:   next_state = EXEC;
        EXEC:    if (!stall) next_state = FETCH;
        default: next_state = FETCH;
      endcase
    end
  end

  // Selection picks targets registered at the previous commit, giving one delay slot.
  always_comb begin
    sel_pc = pc4;
    case (jump_addr_selection)
      2'b00:   sel_pc = pc4;
      2'b01:   sel_pc = tgt_abs;
      2'b10:   sel_pc = tgt_page;
      2'b11:   sel_pc = tgt_rel;
      default: sel_pc = pc4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_now;
  assign misaligned_now = (sel_pc[1:0] != 2'b00);
  assign halt_now       = misaligned_now || (sel_pc == HALT_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_misaligned <= 1'b0;
    end else if (commit && misaligned_now) begin
      addr_misaligned <= 1'b1;
    end
  end
`else
  assign halt_now = (sel_pc == HALT_ADDR);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
      pc        <= RESET_VECTOR;
      active    <= 1'b1;
      tgt_abs   <= 32'd0;
      tgt_page  <= 32'd0;
      tgt_rel   <= 32'd0;
    end else begin
      cur_state <= next_state;
      if (commit) begin
        tgt_abs  <= rs_data;
        tgt_page <= {pc4[31:28], instr_word[25:0], 2'b00};
        tgt_rel  <= pc4 + {{14{instr_word[15]}}, instr_word[15:0], 2'b00};
        if (halt_now) begin
          pc     <= HALT_ADDR;
          active <= 1'b0;
        end else begin
          pc <= sel_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: reference model feeds an expected-pc queue popped at each commit.
// Builds with or without PC_ALIGN_CHECK_EN.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  jump_addr_selection = 2'b00;
  logic [31:0] instr_word = 32'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] pc;
  logic        state;
  logic [31:0] link_addr;
  logic        active;
`ifdef PC_ALIGN_CHECK_EN
  logic        addr_misaligned;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_pc, m_abs, m_page, m_rel;
  logic        m_active, m_mis;

  pc_sequencer dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .jump_addr_selection(jump_addr_selection),
    .instr_word(instr_word),
    .rs_data(rs_data),
    .pc(pc),
    .state(state),
    .link_addr(link_addr),
    .active(active)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .addr_misaligned(addr_misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RV; m_abs = 0; m_page = 0; m_rel = 0; m_active = 1'b1; m_mis = 1'b0;
  endtask

  task automatic model_commit(input logic [31:0] iw, input logic [31:0] rs, input logic [1:0] sel);
    logic [31:0] p4, np;
    p4 = m_pc + 32'd4;
    case (sel)
      2'b01:   np = m_abs;
      2'b10:   np = m_page;
      2'b11:   np = m_rel;
      default: np = p4;
    endcase
    m_abs  = rs;
    m_page = {p4[31:28], iw[25:0], 2'b00};
    m_rel  = p4 + {{14{iw[15]}}, iw[15:0], 2'b00};
`ifdef PC_ALIGN_CHECK_EN
    if (np[1:0] != 2'b00) begin
      m_mis = 1'b1; np = 32'd0;
    end
`endif
    if (np == 32'd0) m_active = 1'b0;
    m_pc = np;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 1'b0; jump_addr_selection = 2'b00;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // One instruction: FETCH cycle, EXEC (optionally stalled), commit; sel presented at the commit.
  task automatic do_instr(input logic [31:0] iw, input logic [31:0] rs, input logic [1:0] sel,
                          input int stall_n);
    logic [31:0] got;
    checks++;
    if (state !== 1'b0) begin
      failures++; $display("FAIL fetch_state got=%0b exp=0 pc=%h", state, m_pc);
    end
    tick();
    checks++;
    if (state !== 1'b1) begin
      failures++; $display("FAIL exec_state got=%0b exp=1", state);
    end
    checks++;
    if (link_addr !== m_pc + 32'd8) begin
      failures++; $display("FAIL link_addr got=%h exp=%h", link_addr, m_pc + 32'd8);
    end
    instr_word = iw; rs_data = rs; stall = (stall_n > 0);
    jump_addr_selection = (stall_n > 0) ? 2'($urandom_range(0, 3)) : sel;
    for (int i = 0; i < stall_n; i++) begin
      tick();
      checks++;
      if (pc !== m_pc || state !== 1'b1) begin
        failures++; $display("FAIL stall_hold pc=%h exp=%h state=%0b", pc, m_pc, state);
      end
      if (i == stall_n - 1) begin
        stall = 1'b0; jump_addr_selection = sel;
      end else begin
        jump_addr_selection = 2'($urandom_range(0, 3));
      end
    end
    model_commit(iw, rs, sel);
    exp_q.push_back(m_pc);
    tick();
    jump_addr_selection = 2'b00;
    got = exp_q.pop_front();
    checks++;
    if (pc !== got) begin
      failures++; $display("FAIL commit_pc got=%h exp=%h", pc, got);
    end
    checks++;
    if (active !== m_active) begin
      failures++; $display("FAIL commit_active got=%0b exp=%0b", active, m_active);
    end
  endtask

  task automatic check_frozen(input logic [31:0] exp_pc, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (state !== 1'b0 || pc !== exp_pc || active !== 1'b0) begin
        failures++;
        $display("FAIL halted state=%0b pc=%h active=%0b exp pc=%h", state, pc, active, exp_pc);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (pc !== RV || state !== 1'b0 || active !== 1'b1) begin
      failures++; $display("FAIL reset pc=%h state=%0b active=%0b", pc, state, active);
    end
`ifdef PC_ALIGN_CHECK_EN
    checks++;
    if (addr_misaligned !== 1'b0) begin
      failures++; $display("FAIL reset_misaligned got=%0b exp=0", addr_misaligned);
    end
`endif
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) do_instr(32'd0, 32'h1234_5678, 2'b00, 0);
    checks++;
    if (pc !== 32'hBFC0_000C) begin
      failures++; $display("FAIL seq_pc got=%h exp=BFC0000C", pc);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    do_instr(32'h1000_0004, 32'd0, 2'b00, 0);
    checks++;
    if (pc !== 32'hBFC0_0004) begin
      failures++; $display("FAIL beq_slot got=%h exp=BFC00004", pc);
    end
    do_instr(32'd0, 32'd0, 2'b11, 0);
    checks++;
    if (pc !== 32'hBFC0_0014) begin
      failures++; $display("FAIL beq_target got=%h exp=BFC00014", pc);
    end
  endtask

  task automatic test_jump_page();
    apply_reset();
    for (int i = 0; i < 4; i++) do_instr(32'd0, 32'd0, 2'b00, 0);
    tick();
    checks++;
    if (link_addr !== 32'hBFC0_0018) begin
      failures++; $display("FAIL j_link got=%h exp=BFC00018", link_addr);
    end
    instr_word = 32'h0800_0100;
    model_commit(32'h0800_0100, 32'd0, 2'b00);
    tick();
    instr_word = 32'd0;
    do_instr(32'd0, 32'd0, 2'b10, 0);
    checks++;
    if (pc !== 32'hB000_0400) begin
      failures++; $display("FAIL j_target got=%h exp=B0000400", pc);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    do_instr(32'd0, 32'd0, 2'b00, 3);
    do_instr(32'h1000_0008, 32'h2000_0000, 2'b00, 2);
    checks++;
    if (pc !== 32'hBFC0_0008) begin
      failures++; $display("FAIL stall_advance got=%h exp=BFC00008", pc);
    end
    do_instr(32'd0, 32'd0, 2'b01, 3);
    checks++;
    if (pc !== 32'h2000_0000) begin
      failures++; $display("FAIL stall_jr got=%h exp=20000000", pc);
    end
  endtask

  task automatic test_halt_jr();
    apply_reset();
    do_instr(32'd0, 32'd0, 2'b00, 0);
    do_instr(32'd0, 32'd0, 2'b00, 0);
    do_instr(32'd0, 32'd0, 2'b00, 0);
    checks++;
    if (pc !== 32'hBFC0_000C) begin
      failures++; $display("FAIL jr_slot got=%h exp=BFC0000C", pc);
    end
    do_instr(32'd0, 32'd0, 2'b01, 0);
    checks++;
    if (pc !== 32'd0 || active !== 1'b0) begin
      failures++; $display("FAIL jr_halt pc=%h active=%0b exp pc=0 active=0", pc, active);
    end
    check_frozen(32'd0, 4);
  endtask

  task automatic test_wrap();
    apply_reset();
    do_instr(32'd0, 32'hFFFF_FFF8, 2'b00, 0);
    do_instr(32'd0, 32'd0, 2'b01, 0);
    do_instr(32'd0, 32'd0, 2'b00, 0);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_pre got=%h exp=FFFFFFFC", pc);
    end
    do_instr(32'd0, 32'd0, 2'b00, 0);
    check_frozen(32'd0, 2);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_instr(32'h1000_0040, 32'h3000_0000, 2'b00, 0);
    tick();
    instr_word = 32'h1000_0040; jump_addr_selection = 2'b11;
    reset = 1'b1;
    tick();
    checks++;
    if (pc !== RV || state !== 1'b0 || active !== 1'b1) begin
      failures++; $display("FAIL reset_mid pc=%h state=%0b active=%0b", pc, state, active);
    end
    reset = 1'b0; jump_addr_selection = 2'b00;
    model_reset();
    // Cleared relative target is 0, so selecting it must halt.
    do_instr(32'd0, 32'd0, 2'b11, 0);
    check_frozen(32'd0, 2);
  endtask

  task automatic test_misaligned();
    apply_reset();
    do_instr(32'd0, 32'hBFC0_0022, 2'b00, 0);
    do_instr(32'd0, 32'd0, 2'b01, 0);
`ifdef PC_ALIGN_CHECK_EN
    checks++;
    if (addr_misaligned !== 1'b1 || pc !== 32'd0 || active !== 1'b0) begin
      failures++;
      $display("FAIL misaligned flag=%0b pc=%h active=%0b exp 1/0/0", addr_misaligned, pc, active);
    end
    check_frozen(32'd0, 2);
`else
    checks++;
    if (pc !== 32'hBFC0_0022 || active !== 1'b1) begin
      failures++; $display("FAIL misaligned_pass pc=%h exp=BFC00022 active=%0b", pc, active);
    end
`endif
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      if (!m_active) break;
      do_instr($urandom(), $urandom() & 32'hFFFF_FFFC | 32'h0001_0000,
               2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_page();
    test_stall();
    test_halt_jr();
    test_wrap();
    test_reset_mid();
    test_misaligned();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
